// File: rtl/ctr_phase_offset_multi.sv
// Push-button phase-offset controller: one signed offset per channel, adjusted in
// power-of-two steps, with saturating or wrapping arithmetic and a 3-digit status display.
module ctr_phase_offset_multi #(
  parameter int SIZE_PHASE = 9,
  parameter int NUM_CH     = 4,
  parameter int MAX_SHIFT  = 7,
  parameter int SAT_MODE   = 1,
  parameter int SIZE_SEG   = 7
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_en,
  input  logic                             i_btn_ch,
  input  logic                             i_btn_step,
  input  logic                             i_btn_up,
  input  logic                             i_btn_dn,
  input  logic                             i_clr,
  output logic [NUM_CH*(SIZE_PHASE+1)-1:0] o_phase_off,
  output logic [NUM_CH*SIZE_PHASE-1:0]     o_phase_mag,
  output logic [NUM_CH-1:0]                o_update,
  output logic [$clog2(NUM_CH)-1:0]        o_ch_sel,
  output logic [SIZE_SEG-1:0]              o_hex_0,
  output logic [SIZE_SEG-1:0]              o_hex_1,
  output logic [SIZE_SEG-1:0]              o_hex_2
);

  localparam int W  = SIZE_PHASE + 1;
  localparam int CW = $clog2(NUM_CH);
  localparam int KW = 4;

  localparam int B_CH   = 0;
  localparam int B_STEP = 1;
  localparam int B_UP   = 2;
  localparam int B_DN   = 3;

  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [W-1:0] OFF_MAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] OFF_MIN = {1'b1, {(W-1){1'b0}}};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    seg7 = SEG_BLANK;
    case (d)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      4'hF: seg7 = 7'h0E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchronisers and falling-edge detectors
  // ---------------------------------------------------------------------------
  logic [3:0] btn_raw;
  logic [3:0] s1, s2, s3;
  logic [3:0] armed;
  logic [1:0] prime;
  logic [3:0] evt;
  logic       clr_g;

  assign btn_raw = {i_btn_dn, i_btn_up, i_btn_step, i_btn_ch};

  // A button only arms once a genuine high level has reached s2 after reset, so a
  // button held through reset release cannot masquerade as a fresh press.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      s1    <= '1;
      s2    <= '1;
      s3    <= '1;
      prime <= '0;
      armed <= '0;
    end else begin
      s1    <= btn_raw;
      s2    <= s1;
      s3    <= s2;
      prime <= {prime[0], 1'b1};
      if (prime[1]) armed <= armed | s2;
    end
  end

  assign evt   = s3 & ~s2 & armed & {4{i_en}};
  assign clr_g = i_clr & i_en;

  // ---------------------------------------------------------------------------
  // Offset update datapath for the selected channel
  // ---------------------------------------------------------------------------
  logic [W-1:0]          off_q [NUM_CH];
  logic [SIZE_PHASE-1:0] mag_q [NUM_CH];
  logic [CW-1:0]         ch_q;
  logic [KW-1:0]         k_q;

  logic [W-1:0]          cur;
  logic [W:0]            step;
  logic [W:0]            sum;
  logic                  ovf;
  logic [W-1:0]          adj;
  logic [W-1:0]          nxt;
  logic [SIZE_PHASE-1:0] nxt_mag;
  logic                  changed;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    cur     = off_q[ch_q];
    step    = (W+1)'(1) << k_q;
    sum     = '0;
    adj     = cur;
    nxt     = cur;
    nxt_mag = '0;

    // One extra bit of headroom lets the top two bits flag overflow either way.
    if (evt[B_UP]) sum = {cur[W-1], cur} + step;
    else           sum = {cur[W-1], cur} - step;
    ovf = sum[W] ^ sum[W-1];

    if (SAT_MODE != 0 && ovf) adj = sum[W] ? OFF_MIN : OFF_MAX;
    else                      adj = sum[W-1:0];

    if (clr_g)                     nxt = '0;
    else if (evt[B_UP] ^ evt[B_DN]) nxt = adj;

    if (nxt == OFF_MIN)  nxt_mag = '1;
    else if (nxt[W-1])   nxt_mag = SIZE_PHASE'(0) - nxt[SIZE_PHASE-1:0];
    else                 nxt_mag = nxt[SIZE_PHASE-1:0];

    changed = (nxt != cur);
  end

  // ---------------------------------------------------------------------------
  // State, pulses and display registers
  // ---------------------------------------------------------------------------
  // NOTE: the offset/magnitude arrays are plain flops, not RAM, so they take the async reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int c = 0; c < NUM_CH; c++) begin
        off_q[c] <= '0;
        mag_q[c] <= '0;
      end
      o_update <= '0;
      ch_q     <= '0;
      k_q      <= '0;
      o_hex_0  <= SIZE_SEG'(seg7(4'h0));
      o_hex_1  <= SIZE_SEG'(seg7(4'h0));
      o_hex_2  <= SIZE_SEG'(SEG_BLANK);
    end else begin
      o_update <= '0;
      if (changed) begin
        off_q[ch_q]    <= nxt;
        mag_q[ch_q]    <= nxt_mag;
        o_update[ch_q] <= 1'b1;
      end

      // Selection and step advance after the update has used the old values.
      if (evt[B_CH])
        ch_q <= (ch_q == CW'(NUM_CH - 1)) ? '0 : ch_q + 1'b1;
      if (evt[B_STEP])
        k_q <= (k_q == KW'(MAX_SHIFT)) ? '0 : k_q + 1'b1;

      o_hex_0 <= SIZE_SEG'(seg7(KW'(ch_q)));
      o_hex_1 <= SIZE_SEG'(seg7(k_q));
      o_hex_2 <= SIZE_SEG'(off_q[ch_q][W-1] ? SEG_DASH : SEG_BLANK);
    end
  end

  assign o_ch_sel = ch_q;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_pack
    assign o_phase_off[c*W +: W]                   = off_q[c];
    assign o_phase_mag[c*SIZE_PHASE +: SIZE_PHASE] = mag_q[c];
  end

endmodule

// File: tb/tb_ctr_phase_offset_multi.sv
// Directed bench driving a saturating and a wrapping instance side by side; expected
// state comes from an integer model pushed into a scoreboard queue at each press.
module tb_ctr_phase_offset_multi;

  localparam int SP = 9;
  localparam int NC = 4;
  localparam int W  = SP + 1;
  localparam int MS = 7;

  localparam logic [6:0] SEG_TAB [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  typedef struct packed {
    logic [NC*W-1:0]  off_s;
    logic [NC*W-1:0]  off_w;
    logic [NC*SP-1:0] mag_s;
    logic [NC*SP-1:0] mag_w;
    logic [NC-1:0]    upd_s;
    logic [NC-1:0]    upd_w;
    logic [1:0]       ch;
    logic [6:0]       hex0;
    logic [6:0]       hex1;
    logic [6:0]       hex2s;
    logic [6:0]       hex2w;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst_n, i_en, btn_ch, btn_step, btn_up, btn_dn, i_clr;

  logic [NC*W-1:0]  off_s, off_w;
  logic [NC*SP-1:0] mag_s, mag_w;
  logic [NC-1:0]    upd_s, upd_w;
  logic [1:0]       ch_s, ch_w;
  logic [6:0]       h0_s, h1_s, h2_s, h0_w, h1_w, h2_w;

  int   n_checks = 0;
  int   n_errors = 0;
  int   m_sat [NC];
  int   m_wrap[NC];
  int   m_ch, m_k;
  exp_t exp_q[$];

  always #5 i_clk = ~i_clk;

  ctr_phase_offset_multi #(.SIZE_PHASE(SP), .NUM_CH(NC), .MAX_SHIFT(MS), .SAT_MODE(1), .SIZE_SEG(7)) dut_sat (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_btn_ch(btn_ch), .i_btn_step(btn_step), .i_btn_up(btn_up), .i_btn_dn(btn_dn), .i_clr(i_clr),
    .o_phase_off(off_s), .o_phase_mag(mag_s), .o_update(upd_s), .o_ch_sel(ch_s),
    .o_hex_0(h0_s), .o_hex_1(h1_s), .o_hex_2(h2_s)
  );

  ctr_phase_offset_multi #(.SIZE_PHASE(SP), .NUM_CH(NC), .MAX_SHIFT(MS), .SAT_MODE(0), .SIZE_SEG(7)) dut_wrap (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_en(i_en),
    .i_btn_ch(btn_ch), .i_btn_step(btn_step), .i_btn_up(btn_up), .i_btn_dn(btn_dn), .i_clr(i_clr),
    .o_phase_off(off_w), .o_phase_mag(mag_w), .o_update(upd_w), .o_ch_sel(ch_w),
    .o_hex_0(h0_w), .o_hex_1(h1_w), .o_hex_2(h2_w)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int apply(input int cur, input bit up, input bit dn, input bit clr,
                               input int k, input bit sat);
    int v;
    if (clr) return 0;
    if (up == dn) return cur;
    v = up ? cur + (1 << k) : cur - (1 << k);
    if (sat) begin
      if (v > 511)  v = 511;
      if (v < -512) v = -512;
    end else begin
      v = ((v + 2560) % 1024) - 512;
    end
    return v;
  endfunction

  function automatic int mag_of(input int v);
    if (v == -512) return 511;
    return (v < 0) ? -v : v;
  endfunction

  function automatic exp_t snapshot(input logic [NC-1:0] us, input logic [NC-1:0] uw);
    exp_t e;
    e = '0;
    for (int c = 0; c < NC; c++) begin
      e.off_s[c*W +: W]   = W'(m_sat[c]);
      e.off_w[c*W +: W]   = W'(m_wrap[c]);
      e.mag_s[c*SP +: SP] = SP'(mag_of(m_sat[c]));
      e.mag_w[c*SP +: SP] = SP'(mag_of(m_wrap[c]));
    end
    e.upd_s = us;
    e.upd_w = uw;
    e.ch    = 2'(m_ch);
    e.hex0  = SEG_TAB[m_ch];
    e.hex1  = SEG_TAB[m_k];
    e.hex2s = (m_sat[m_ch] < 0) ? 7'h3F : 7'h7F;
    e.hex2w = (m_wrap[m_ch] < 0) ? 7'h3F : 7'h7F;
    return e;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_sat[c]  = 0;
      m_wrap[c] = 0;
    end
    m_ch = 0;
    m_k  = 0;
  endtask

  // One press of any button combination (clr is a level asserted for the update edge).
  task automatic press(input bit b_ch, input bit b_step, input bit b_up, input bit b_dn,
                       input bit b_clr, input string tag);
    exp_t          prev, nx;
    logic [NC-1:0] us, uw;
    int            oc, ok, ns, nw;
    bit            en;
    en   = i_en;
    prev = snapshot('0, '0);
    oc   = m_ch;
    ok   = m_k;
    us   = '0;
    uw   = '0;
    ns   = apply(m_sat[oc],  b_up & en, b_dn & en, b_clr & en, ok, 1'b1);
    nw   = apply(m_wrap[oc], b_up & en, b_dn & en, b_clr & en, ok, 1'b0);
    if (ns != m_sat[oc])  us[oc] = 1'b1;
    if (nw != m_wrap[oc]) uw[oc] = 1'b1;
    m_sat[oc]  = ns;
    m_wrap[oc] = nw;
    if (b_ch && en)   m_ch = (m_ch + 1) % NC;
    if (b_step && en) m_k  = (m_k == MS) ? 0 : m_k + 1;
    exp_q.push_back(snapshot(us, uw));

    @(negedge i_clk);
    btn_ch = ~b_ch; btn_step = ~b_step; btn_up = ~b_up; btn_dn = ~b_dn;
    @(posedge i_clk);            // edge E
    @(posedge i_clk); #1;        // edge E+1: nothing may have moved yet
    check({tag, "/early_off"}, 64'(off_s), 64'(prev.off_s));
    check({tag, "/early_upd"}, 64'(upd_s), 64'(0));
    i_clr = b_clr;
    @(posedge i_clk); #1;        // edge E+2: state and pulse
    i_clr = 1'b0;
    nx = exp_q.pop_front();
    check({tag, "/off_s"}, 64'(off_s), 64'(nx.off_s));
    check({tag, "/off_w"}, 64'(off_w), 64'(nx.off_w));
    check({tag, "/mag_s"}, 64'(mag_s), 64'(nx.mag_s));
    check({tag, "/mag_w"}, 64'(mag_w), 64'(nx.mag_w));
    check({tag, "/upd_s"}, 64'(upd_s), 64'(nx.upd_s));
    check({tag, "/upd_w"}, 64'(upd_w), 64'(nx.upd_w));
    check({tag, "/ch_s"},  64'(ch_s),  64'(nx.ch));
    check({tag, "/ch_w"},  64'(ch_w),  64'(nx.ch));
    @(posedge i_clk); #1;        // edge E+3: pulse gone, displays caught up
    check({tag, "/upd_off"}, 64'({upd_s, upd_w}), 64'(0));
    check({tag, "/hex0"},    64'({h0_s, h0_w}),   64'({nx.hex0, nx.hex0}));
    check({tag, "/hex1"},    64'({h1_s, h1_w}),   64'({nx.hex1, nx.hex1}));
    check({tag, "/hex2"},    64'({h2_s, h2_w}),   64'({nx.hex2s, nx.hex2w}));
    @(negedge i_clk);
    btn_ch = 1'b1; btn_step = 1'b1; btn_up = 1'b1; btn_dn = 1'b1;
    repeat (4) @(posedge i_clk);
    #1;
    check({tag, "/release"}, 64'({upd_s, upd_w}), 64'(0));
  endtask

  logic [NC-1:0] seen;

  initial begin
    i_rst_n = 1'b0; i_en = 1'b1; i_clr = 1'b0;
    btn_ch = 1'b1; btn_step = 1'b1; btn_up = 1'b1; btn_dn = 1'b1;
    model_reset();
    repeat (3) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    repeat (10) @(posedge i_clk);
    #1;
    check("rst/off",  64'({off_s, 24'h0}) | 64'(off_w), 64'(0));
    check("rst/mag",  64'({mag_s, mag_w}), 64'(0));
    check("rst/upd",  64'({upd_s, upd_w}), 64'(0));
    check("rst/ch",   64'({ch_s, ch_w}),   64'(0));
    check("rst/hex",  64'({h0_s, h1_s, h2_s}), 64'({7'h40, 7'h40, 7'h7F}));

    // Step to k=3, then +8 and two -8 on channel 0.
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0, 0, "step_k3");
    press(0, 0, 1, 0, 0, "up8");
    press(0, 0, 0, 1, 0, "dn_to0");
    press(0, 0, 0, 1, 0, "dn_to_m8");
    for (int i = 0; i < 8; i++) press(0, 1, 0, 0, 0, "step_wrap");
    press(0, 0, 0, 0, 1, "clr");
    press(0, 0, 0, 0, 1, "clr_zero");

    // k=7: saturation on one instance, wrap-around on the other.
    for (int i = 0; i < 4; i++) press(0, 1, 0, 0, 0, "step_k7");
    for (int i = 0; i < 5; i++) press(0, 0, 1, 0, 0, "up_limit");
    for (int i = 0; i < 9; i++) press(0, 0, 0, 1, 0, "dn_limit");

    // Simultaneous events.
    press(1, 0, 1, 0, 0, "ch_up");
    press(0, 0, 1, 0, 0, "up_ch1");
    press(0, 0, 1, 1, 0, "up_dn");
    press(0, 0, 1, 0, 1, "clr_up");
    press(0, 1, 1, 0, 0, "step_up");

    // Disabled: presses and clear are ignored.
    i_en = 1'b0;
    press(0, 0, 1, 0, 0, "dis_up");
    press(0, 0, 0, 1, 1, "dis_dn_clr");
    press(1, 1, 0, 0, 0, "dis_ch_step");
    i_en = 1'b1;

    // Build off[2] = 40, then reset mid-operation.
    press(1, 0, 0, 0, 0, "ch2");
    for (int i = 0; i < 3; i++) press(0, 1, 0, 0, 0, "step_k3b");
    for (int i = 0; i < 5; i++) press(0, 0, 1, 0, 0, "up40");
    @(negedge i_clk);
    #2 i_rst_n = 1'b0;
    #1;
    check("async_rst/off", 64'({off_s, 24'h0}) | 64'(off_w), 64'(0));
    check("async_rst/ch",  64'({ch_s, ch_w}), 64'(0));
    check("async_rst/hex", 64'({h0_s, h1_s, h2_s}), 64'({7'h40, 7'h40, 7'h7F}));
    model_reset();

    // Up button held through reset release must not produce an event.
    btn_up = 1'b0;
    repeat (2) @(posedge i_clk);
    @(negedge i_clk) i_rst_n = 1'b1;
    seen = '0;
    for (int i = 0; i < 10; i++) begin
      @(posedge i_clk); #1;
      seen = seen | upd_s | upd_w;
    end
    check("held/upd", 64'(seen), 64'(0));
    check("held/off", 64'({off_s, 24'h0}) | 64'(off_w), 64'(0));
    @(negedge i_clk) btn_up = 1'b1;
    repeat (6) @(posedge i_clk);
    #1;
    check("held/release", 64'({off_s, 24'h0}) | 64'(off_w), 64'(0));
    press(0, 0, 1, 0, 0, "after_held");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
